// File: rtl/bp_fe_bht_update_sched_pkg.sv
// Shared front-end BHT scheduler types: FSM states, init value, the buffered
// update entry and the 2-bit saturating counter step.
package bp_fe_bht_update_sched_pkg;

    typedef enum logic [0:0] {
        e_bht_init = 1'b0,
        e_bht_run  = 1'b1
    } bp_fe_bht_sched_state_e;

    localparam logic [1:0] bht_init_val_gp = 2'b01;

    // Entries carry the widest supported index; narrower tables use the low bits.
    localparam int bht_idx_max_width_gp = 16;

    typedef struct packed {
        logic [bht_idx_max_width_gp-1:0] idx;
        logic [1:0]                      val;
        logic                            taken;
        logic                            correct;
    } bp_fe_bht_upd_s;

    function automatic logic [1:0] bht_sat_update(input logic [1:0] val, input logic taken);
        logic [1:0] res;
        if (taken) begin
            res = (val == 2'b11) ? 2'b11 : val + 2'b01;
        end else begin
            res = (val == 2'b00) ? 2'b00 : val - 2'b01;
        end
        return res;
    endfunction

endpackage

// File: rtl/bp_fe_bht_update_sched_fifo.sv
// Small register-based 1R1W FIFO with synchronous flush; holds pending BHT
// updates. Head is presented combinationally on data_o.
module bsg_fifo_1r1w_small #(
    parameter int width_p = 8,
    parameter int els_p   = 2
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               clr_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    input  logic               yumi_i,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    output logic               full_o
);

    localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int cnt_w_lp = $clog2(els_p + 1);
    localparam logic [ptr_w_lp-1:0] ptr_last_lp = ptr_w_lp'(els_p - 1);
    localparam logic [ptr_w_lp-1:0] ptr_one_lp  = {{(ptr_w_lp-1){1'b0}}, 1'b1};
    localparam logic [cnt_w_lp-1:0] cnt_full_lp = cnt_w_lp'(els_p);
    localparam logic [cnt_w_lp-1:0] cnt_one_lp  = {{(cnt_w_lp-1){1'b0}}, 1'b1};

    logic [width_p-1:0]  mem_r [els_p];
    logic [ptr_w_lp-1:0] rptr_r;
    logic [ptr_w_lp-1:0] wptr_r;
    logic [cnt_w_lp-1:0] cnt_r;
    logic                enq_s;
    logic                deq_s;

    assign v_o    = (cnt_r != {cnt_w_lp{1'b0}});
    assign full_o = (cnt_r == cnt_full_lp);
    assign enq_s  = v_i & ~full_o;
    assign deq_s  = yumi_i & v_o;
    assign data_o = mem_r[rptr_r];

    // Storage array; contents are meaningless while the count says empty.
    always_ff @(posedge clk_i) begin
        if (enq_s) begin
            mem_r[wptr_r] <= data_i;
        end
    end

    // Pointers and occupancy; flush overrides any same-cycle enqueue/dequeue.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            rptr_r <= {ptr_w_lp{1'b0}};
            wptr_r <= {ptr_w_lp{1'b0}};
            cnt_r  <= {cnt_w_lp{1'b0}};
        end else if (clr_i) begin
            rptr_r <= {ptr_w_lp{1'b0}};
            wptr_r <= {ptr_w_lp{1'b0}};
            cnt_r  <= {cnt_w_lp{1'b0}};
        end else begin
            if (enq_s) begin
                wptr_r <= (wptr_r == ptr_last_lp) ? {ptr_w_lp{1'b0}} : wptr_r + ptr_one_lp;
            end
            if (deq_s) begin
                rptr_r <= (rptr_r == ptr_last_lp) ? {ptr_w_lp{1'b0}} : rptr_r + ptr_one_lp;
            end
            case ({enq_s, deq_s})
                2'b10:   cnt_r <= cnt_r + cnt_one_lp;
                2'b01:   cnt_r <= cnt_r - cnt_one_lp;
                default: cnt_r <= cnt_r;
            endcase
        end
    end

endmodule

// File: rtl/bp_fe_bht_update_sched.sv
// BHT write-port scheduler: sweeps the table to weakly-not-taken, then drains
// buffered resolved-branch updates whenever fetch is not reading.
// Optional statistics counters are built when BP_BHT_SCHED_STATS_EN is defined.
module bp_fe_bht_update_sched
    import bp_fe_bht_update_sched_pkg::*;
#(
    parameter int bht_idx_width_p = 9,
    parameter int fifo_els_p      = 2,
    parameter int stat_width_p    = 32
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       clear_i,
    output logic                       init_done_o,
    input  logic                       upd_v_i,
    output logic                       upd_ready_o,
    input  logic [bht_idx_width_p-1:0] upd_idx_i,
    input  logic [1:0]                 upd_val_i,
    input  logic                       upd_taken_i,
    input  logic                       upd_correct_i,
    input  logic                       r_v_i,
    output logic                       w_v_o,
    output logic [bht_idx_width_p-1:0] w_idx_o,
    output logic [1:0]                 w_data_o,
    output logic                       w_correct_o,
    output logic [stat_width_p-1:0]    stat_correct_o,
    output logic [stat_width_p-1:0]    stat_mispred_o
);

    localparam logic [bht_idx_width_p-1:0] sweep_last_lp = {bht_idx_width_p{1'b1}};
    localparam logic [bht_idx_width_p-1:0] sweep_one_lp  = {{(bht_idx_width_p-1){1'b0}}, 1'b1};

    bp_fe_bht_sched_state_e     state_r;
    logic [bht_idx_width_p-1:0] sweep_r;
    bp_fe_bht_upd_s             enq_entry_s;
    bp_fe_bht_upd_s             head_s;
    logic                       head_v_s;
    logic                       full_s;
    logic                       run_s;
    logic                       enq_s;
    logic                       deq_s;

    assign run_s       = (state_r == e_bht_run);
    assign init_done_o = run_s;
    // Ready uses registered fullness, so a full buffer never refills on its dequeue cycle.
    assign upd_ready_o = run_s & ~full_s & ~clear_i;
    assign enq_s       = upd_v_i & upd_ready_o;
    assign deq_s       = run_s & head_v_s & ~r_v_i;

    // Pack the incoming update into a buffer entry.
    always_comb begin
        enq_entry_s                            = '0;
        enq_entry_s.idx[bht_idx_width_p-1:0]   = upd_idx_i;
        enq_entry_s.val                        = upd_val_i;
        enq_entry_s.taken                      = upd_taken_i;
        enq_entry_s.correct                    = upd_correct_i;
    end

    bsg_fifo_1r1w_small #(
        .width_p ($bits(bp_fe_bht_upd_s)),
        .els_p   (fifo_els_p)
    ) upd_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clr_i   (clear_i),
        .v_i     (enq_s),
        .data_i  (enq_entry_s),
        .yumi_i  (deq_s),
        .v_o     (head_v_s),
        .data_o  (head_s),
        .full_o  (full_s)
    );

    if (bht_idx_width_p < bht_idx_max_width_gp) begin : g_idx_hi
        logic unused_idx_hi_s;
        assign unused_idx_hi_s = ^head_s.idx[bht_idx_max_width_gp-1:bht_idx_width_p];
    end

    // INIT/RUN sequencing and the table sweep counter.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_r <= e_bht_init;
            sweep_r <= {bht_idx_width_p{1'b0}};
        end else begin
            case (state_r)
                e_bht_init: begin
                    if (clear_i) begin
                        sweep_r <= {bht_idx_width_p{1'b0}};
                    end else if (sweep_r == sweep_last_lp) begin
                        state_r <= e_bht_run;
                        sweep_r <= {bht_idx_width_p{1'b0}};
                    end else begin
                        sweep_r <= sweep_r + sweep_one_lp;
                    end
                end
                e_bht_run: begin
                    if (clear_i) begin
                        state_r <= e_bht_init;
                        sweep_r <= {bht_idx_width_p{1'b0}};
                    end else begin
                        sweep_r <= sweep_r;
                    end
                end
                default: begin
                    state_r <= e_bht_init;
                    sweep_r <= {bht_idx_width_p{1'b0}};
                end
            endcase
        end
    end

    // Write port: sweep writes in INIT, buffer head with counter step in RUN.
    always_comb begin
        w_v_o       = 1'b1;
        w_idx_o     = sweep_r;
        w_data_o    = bht_init_val_gp;
        w_correct_o = 1'b0;
        case (state_r)
            e_bht_init: begin
                w_v_o       = 1'b1;
                w_idx_o     = sweep_r;
                w_data_o    = bht_init_val_gp;
                w_correct_o = 1'b0;
            end
            e_bht_run: begin
                w_v_o       = deq_s;
                w_idx_o     = head_s.idx[bht_idx_width_p-1:0];
                w_data_o    = bht_sat_update(head_s.val, head_s.taken);
                w_correct_o = head_s.correct;
            end
            default: begin
                w_v_o       = 1'b1;
                w_idx_o     = sweep_r;
                w_data_o    = bht_init_val_gp;
                w_correct_o = 1'b0;
            end
        endcase
    end

`ifdef BP_BHT_SCHED_STATS_EN
    localparam logic [stat_width_p-1:0] stat_one_lp = {{(stat_width_p-1){1'b0}}, 1'b1};

    logic [stat_width_p-1:0] stat_correct_r;
    logic [stat_width_p-1:0] stat_mispred_r;

    // Prediction statistics, counted at the update handshake; survive clear_i.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            stat_correct_r <= {stat_width_p{1'b0}};
            stat_mispred_r <= {stat_width_p{1'b0}};
        end else if (enq_s) begin
            if (upd_correct_i) begin
                stat_correct_r <= stat_correct_r + stat_one_lp;
            end else begin
                stat_mispred_r <= stat_mispred_r + stat_one_lp;
            end
        end else begin
            stat_correct_r <= stat_correct_r;
            stat_mispred_r <= stat_mispred_r;
        end
    end

    assign stat_correct_o = stat_correct_r;
    assign stat_mispred_o = stat_mispred_r;
`else
    assign stat_correct_o = {stat_width_p{1'b0}};
    assign stat_mispred_o = {stat_width_p{1'b0}};
`endif

endmodule

// File: tb/tb_bp_fe_bht_update_sched.sv
// Scoreboard bench for bp_fe_bht_update_sched with a 16-entry table.
module tb_bp_fe_bht_update_sched;

    localparam int W = 4;

    logic          clk = 1'b0;
    logic          reset_i = 1'b0;
    logic          clear_i = 1'b0;
    logic          init_done_o;
    logic          upd_v_i = 1'b0;
    logic          upd_ready_o;
    logic [W-1:0]  upd_idx_i = '0;
    logic [1:0]    upd_val_i = 2'b00;
    logic          upd_taken_i = 1'b0;
    logic          upd_correct_i = 1'b0;
    logic          r_v_i = 1'b0;
    logic          w_v_o;
    logic [W-1:0]  w_idx_o;
    logic [1:0]    w_data_o;
    logic          w_correct_o;
    logic [31:0]   stat_correct_o;
    logic [31:0]   stat_mispred_o;

    bp_fe_bht_update_sched #(
        .bht_idx_width_p (W),
        .fifo_els_p      (2),
        .stat_width_p    (32)
    ) dut (
        .clk_i          (clk),
        .reset_i        (reset_i),
        .clear_i        (clear_i),
        .init_done_o    (init_done_o),
        .upd_v_i        (upd_v_i),
        .upd_ready_o    (upd_ready_o),
        .upd_idx_i      (upd_idx_i),
        .upd_val_i      (upd_val_i),
        .upd_taken_i    (upd_taken_i),
        .upd_correct_i  (upd_correct_i),
        .r_v_i          (r_v_i),
        .w_v_o          (w_v_o),
        .w_idx_o        (w_idx_o),
        .w_data_o       (w_data_o),
        .w_correct_o    (w_correct_o),
        .stat_correct_o (stat_correct_o),
        .stat_mispred_o (stat_mispred_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int idx;
        int data;
        int correct;
        int cyc;
    } exp_wr_t;

    exp_wr_t exp_q[$];
    int      cyc = 0;
    int      checks = 0;
    int      errors = 0;
    bit      mon_en = 1'b0;
    int      exp_corr = 0;
    int      exp_mis = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every write on the port must match the scoreboard head.
    always @(negedge clk) begin
        if (mon_en && reset_i && w_v_o) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write cyc=%0d got idx=%0d data=%0d", cyc, w_idx_o, w_data_o);
            end else begin
                exp_wr_t e;
                e = exp_q.pop_front();
                if (int'(w_idx_o) != e.idx || int'(w_data_o) != e.data ||
                    int'(w_correct_o) != e.correct || (e.cyc >= 0 && cyc != e.cyc)) begin
                    errors++;
                    $display("FAIL write cyc=%0d got idx=%0d data=%0d corr=%0d, expected idx=%0d data=%0d corr=%0d cyc=%0d",
                             cyc, w_idx_o, w_data_o, w_correct_o, e.idx, e.data, e.correct, e.cyc);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_sweep(input int n);
        for (int k = 0; k < n; k++) exp_q.push_back('{k, 1, 0, cyc + k});
    endtask

    // Current window is INIT with sweep 0: expect 16 writes then init_done.
    task automatic expect_init();
        push_sweep(16);
        for (int k = 0; k < 16; k++) begin
            if (k == 0 || k == 15) begin
                chk("init_ready_low", {31'd0, upd_ready_o}, 32'd0);
                chk("init_done_low", {31'd0, init_done_o}, 32'd0);
            end
            tick();
        end
        chk("init_done_high", {31'd0, init_done_o}, 32'd1);
    endtask

    task automatic send(input int idx, input int val, input bit tk, input bit cr,
                        input int exp_data, input bit expect_wr, input int lat);
        chk("upd_ready", {31'd0, upd_ready_o}, 32'd1);
        upd_v_i       = 1'b1;
        upd_idx_i     = W'(idx);
        upd_val_i     = 2'(val);
        upd_taken_i   = tk;
        upd_correct_i = cr;
        if (upd_ready_o) begin
            if (cr) exp_corr++;
            else exp_mis++;
            if (expect_wr) exp_q.push_back('{idx, exp_data, int'(cr), cyc + lat});
        end
        tick();
        upd_v_i = 1'b0;
    endtask

    task automatic chk_stats(input string name);
`ifdef BP_BHT_SCHED_STATS_EN
        chk({name, "_correct"}, stat_correct_o, 32'(exp_corr));
        chk({name, "_mispred"}, stat_mispred_o, 32'(exp_mis));
`else
        chk({name, "_correct"}, stat_correct_o, 32'd0);
        chk({name, "_mispred"}, stat_mispred_o, 32'd0);
`endif
    endtask

    initial begin
        // Reset values
        tick(); tick();
        chk("rst_w_v", {31'd0, w_v_o}, 32'd1);
        chk("rst_w_idx", {28'd0, w_idx_o}, 32'd0);
        chk("rst_w_data", {30'd0, w_data_o}, 32'd1);
        chk("rst_w_correct", {31'd0, w_correct_o}, 32'd0);
        chk("rst_init_done", {31'd0, init_done_o}, 32'd0);
        chk("rst_ready", {31'd0, upd_ready_o}, 32'd0);
        chk_stats("rst_stats");
        reset_i = 1'b1;
        mon_en  = 1'b1;
        expect_init();

        // Counter arithmetic, back-to-back
        send(5, 3, 1'b1, 1'b1, 3, 1'b1, 1);
        send(6, 0, 1'b0, 1'b0, 0, 1'b1, 1);
        send(9, 1, 1'b1, 1'b1, 2, 1'b1, 1);
        send(12, 2, 1'b0, 1'b0, 1, 1'b1, 1);
        tick(); tick();
        chk_stats("arith_stats");

        // Read stall for 3 cycles with two queued updates to the same index
        r_v_i = 1'b1;
        send(3, 1, 1'b1, 1'b1, 2, 1'b1, 3);
        send(3, 2, 1'b1, 1'b0, 3, 1'b1, 3);
        chk("stall_full_ready", {31'd0, upd_ready_o}, 32'd0);
        tick();
        r_v_i = 1'b0;
        tick(); tick(); tick();
        chk("stall_drained", 32'(exp_q.size()), 32'd0);

        // Clear with two pending updates and a same-cycle enqueue attempt
        r_v_i = 1'b1;
        send(7, 0, 1'b1, 1'b1, 1, 1'b0, 0);
        tick();
        send(8, 3, 1'b0, 1'b0, 2, 1'b0, 0);
        tick();
        clear_i       = 1'b1;
        upd_v_i       = 1'b1;
        upd_correct_i = 1'b1;
        #1;
        chk("clear_ready_low", {31'd0, upd_ready_o}, 32'd0);
        tick();
        clear_i = 1'b0;
        upd_v_i = 1'b0;
        r_v_i   = 1'b0;
        expect_init();
        chk_stats("clear_stats");
        tick(); tick();

        // Async reset in the middle of a sweep
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        push_sweep(8);
        for (int k = 0; k < 7; k++) tick();
        @(negedge clk);
        #2;
        mon_en  = 1'b0;
        reset_i = 1'b0;
        #1;
        chk("midrst_w_idx", {28'd0, w_idx_o}, 32'd0);
        chk("midrst_init_done", {31'd0, init_done_o}, 32'd0);
        chk("midrst_sweep_seen", 32'(exp_q.size()), 32'd0);
        exp_corr = 0;
        exp_mis  = 0;
        chk_stats("midrst_stats");
        tick();
        reset_i = 1'b1;
        mon_en  = 1'b1;
        expect_init();

        // Statistics: 3 correct, 2 mispredicted
        send(1, 3, 1'b1, 1'b1, 3, 1'b1, 1);
        send(2, 2, 1'b1, 1'b1, 3, 1'b1, 1);
        send(4, 0, 1'b1, 1'b1, 1, 1'b1, 1);
        send(10, 1, 1'b0, 1'b0, 0, 1'b1, 1);
        send(15, 3, 1'b0, 1'b0, 2, 1'b1, 1);
        tick(); tick();
        chk_stats("final_stats");
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
